// File: rtl/io_pattern_vip.sv
// io_pattern_vip: plays a stored pattern of (value, hold) entries onto io_o
// and independently reports every change seen on io_i.
module io_pattern_vip #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [HOLD_W-1:0]      wr_hold,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] entry_cnt,
    output logic [WIDTH-1:0]       io_o,
    input  logic [WIDTH-1:0]       io_i,
    output logic                   chg_valid,
    output logic [WIDTH-1:0]       chg_data,
    output logic [WIDTH-1:0]       chg_mask,
    output logic [15:0]            chg_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [AW:0] C1 = 1;
    localparam logic [AW-1:0] I1 = 1;
    localparam logic [HOLD_W-1:0] H1 = 1;
    typedef enum logic {IDLE, DRIVE} state_t;
    state_t state;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [HOLD_W-1:0] hold_mem [DEPTH];
    logic [AW-1:0] idx, nxt_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WIDTH-1:0] io_q;
    logic last;

    function automatic logic [HOLD_W-1:0] hmax(input logic [HOLD_W-1:0] h);
        return h == '0 ? H1 : h;
    endfunction

    assign busy = state == DRIVE;
    assign wr_ready = !busy && entry_cnt < FULL;
    assign last = {1'b0, idx} + C1 == entry_cnt;
    assign nxt_idx = last ? '0 : idx + I1;

    always_ff @(posedge clk)
        if (wr_valid && wr_ready && !clear) begin
            data_mem[entry_cnt[AW-1:0]] <= wr_data;
            hold_mem[entry_cnt[AW-1:0]] <= wr_hold;
        end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            done      <= 1'b0;
            io_o      <= '0;
            entry_cnt <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (clear)
                    entry_cnt <= '0;
                else if (wr_valid && wr_ready)
                    entry_cnt <= entry_cnt + C1;
                if (start && entry_cnt != '0) begin
                    state    <= DRIVE;
                    idx      <= '0;
                    io_o     <= data_mem[0];
                    hold_cnt <= hmax(hold_mem[0]);
                end
            end else if (stop) begin
                state <= IDLE;
                done  <= 1'b1;
            end else if (hold_cnt == H1) begin
                // loop_en only matters here, at the wrap from the last entry
                if (last && !loop_en) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    idx      <= nxt_idx;
                    io_o     <= data_mem[nxt_idx];
                    hold_cnt <= hmax(hold_mem[nxt_idx]);
                end
            end else begin
                hold_cnt <= hold_cnt - H1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io_q      <= '0;
            chg_valid <= 1'b0;
            chg_data  <= '0;
            chg_mask  <= '0;
            chg_count <= '0;
        end else begin
            io_q      <= io_i;
            chg_valid <= io_i != io_q;
            if (io_i != io_q) begin
                chg_data <= io_i;
                chg_mask <= io_i ^ io_q;
                if (chg_count != 16'hFFFF)
                    chg_count <= chg_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_io_pattern_vip.sv
// tb_io_pattern_vip: table vectors for the monitor, directed playback corner
// cases, and randomized patterns checked against an expanded expected stream.
module tb_io_pattern_vip;
    localparam int WIDTH = 8, DEPTH = 16, HOLD_W = 16;
    logic clk = 0, resetn = 0, wr_valid = 0, clear = 0, start = 0, stop = 0, loop_en = 0;
    logic [WIDTH-1:0] wr_data = '0, io_i = '0;
    logic [HOLD_W-1:0] wr_hold = '0;
    logic wr_ready, busy, done, chg_valid;
    logic [$clog2(DEPTH):0] entry_cnt;
    logic [WIDTH-1:0] io_o, chg_data, chg_mask;
    logic [15:0] chg_count;
    int vec = 0, errs = 0;
    bit rand_io = 0;
    logic [WIDTH-1:0] m_q = '0, m_data = '0, m_mask = '0;
    logic m_valid = 0;
    logic [15:0] m_count = '0;
    logic [WIDTH-1:0] pd[$];
    int ph[$];

    typedef struct {
        logic [7:0]  in;
        logic        valid;
        logic [7:0]  mask;
        logic [7:0]  data;
        logic [15:0] cnt;
    } mon_vec_t;
    mon_vec_t tbl[7];

    io_pattern_vip #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_hold(wr_hold), .clear(clear), .start(start),
        .stop(stop), .loop_en(loop_en), .busy(busy), .done(done),
        .entry_cnt(entry_cnt), .io_o(io_o), .io_i(io_i), .chg_valid(chg_valid),
        .chg_data(chg_data), .chg_mask(chg_mask), .chg_count(chg_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor reference: a change is any difference from the previous sample.
    task automatic tick();
        if (rand_io) io_i = ($urandom_range(0, 2) == 0) ? io_i : WIDTH'($urandom);
        m_valid = io_i != m_q;
        if (m_valid) begin
            m_data = io_i;
            m_mask = io_i ^ m_q;
            if (m_count != 16'hFFFF) m_count++;
        end
        m_q = io_i;
        @(posedge clk);
        #1;
        if (rand_io) begin
            chk("rnd_chg_valid", chg_valid, m_valid);
            chk("rnd_chg_data", chg_data, m_data);
            chk("rnd_chg_mask", chg_mask, m_mask);
            chk("rnd_chg_count", chg_count, m_count);
        end
    endtask

    task automatic do_reset();
        resetn = 0; wr_valid = 0; clear = 0; start = 0; stop = 0; loop_en = 0; io_i = '0;
        m_q = '0; m_data = '0; m_mask = '0; m_valid = 0; m_count = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
    endtask

    task automatic load();
        clear = 1; tick(); clear = 0;
        foreach (pd[k]) begin
            wr_valid = 1; wr_data = pd[k]; wr_hold = HOLD_W'(ph[k]);
            tick();
        end
        wr_valid = 0;
        chk("load_entry_cnt", entry_cnt, pd.size());
    endtask

    // Expected io_o stream: each entry repeated max(hold,1) times, per pass.
    task automatic run_pattern(input int passes);
        logic [WIDTH-1:0] ex[$];
        int plen;
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < pd.size(); k++)
                for (int r = 0; r < (ph[k] == 0 ? 1 : ph[k]); r++)
                    ex.push_back(pd[k]);
        plen = ex.size() / passes;
        loop_en = (passes > 1);
        start = 1; tick(); start = 0;
        foreach (ex[i]) begin
            chk("play_io_o", io_o, ex[i]);
            chk("play_busy", busy, 1);
            chk("play_done", done, 0);
            if (i == (passes - 1) * plen) loop_en = 0;
            tick();
        end
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_io_o", io_o, ex[ex.size() - 1]);
        tick();
        chk("post_done", done, 0);
        chk("post_io_o", io_o, ex[ex.size() - 1]);
    endtask

    initial begin
        tbl[0] = '{8'h00, 1'b0, 8'h00, 8'h00, 16'd0};
        tbl[1] = '{8'h81, 1'b1, 8'h81, 8'h81, 16'd1};
        tbl[2] = '{8'h81, 1'b0, 8'h81, 8'h81, 16'd1};
        tbl[3] = '{8'h01, 1'b1, 8'h80, 8'h01, 16'd2};
        tbl[4] = '{8'h01, 1'b0, 8'h80, 8'h01, 16'd2};
        tbl[5] = '{8'hFF, 1'b1, 8'hFE, 8'hFF, 16'd3};
        tbl[6] = '{8'h00, 1'b1, 8'hFF, 8'h00, 16'd4};

        do_reset();
        chk("rst_io_o", io_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_entry_cnt", entry_cnt, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_chg_count", chg_count, 0);

        foreach (tbl[i]) begin
            io_i = tbl[i].in;
            tick();
            chk("tbl_chg_valid", chg_valid, tbl[i].valid);
            chk("tbl_chg_mask", chg_mask, tbl[i].mask);
            chk("tbl_chg_data", chg_data, tbl[i].data);
            chk("tbl_chg_count", chg_count, tbl[i].cnt);
        end

        pd = '{8'hA5, 8'h3C, 8'hFF};
        ph = '{3, 0, 2};
        load();
        run_pattern(1);
        run_pattern(3);

        clear = 1; tick(); clear = 0;
        chk("clr_entry_cnt", entry_cnt, 0);
        start = 1; tick(); start = 0;
        chk("empty_start_busy", busy, 0);
        chk("empty_start_done", done, 0);
        tick();
        chk("empty_start_done2", done, 0);

        for (int i = 0; i < DEPTH + 2; i++) begin
            chk("full_wr_ready", wr_ready, i < DEPTH);
            wr_valid = 1;
            wr_data = (i < DEPTH) ? WIDTH'(i * 17 + 8'h11) : 8'hEE;
            wr_hold = 5;
            tick();
        end
        wr_valid = 0;
        chk("full_entry_cnt", entry_cnt, DEPTH);
        chk("full_wr_ready_end", wr_ready, 0);

        start = 1; tick(); start = 0;
        chk("ss_first_io_o", io_o, 8'h11);
        chk("ss_busy", busy, 1);
        tick(); tick();
        stop = 1; start = 1; tick(); stop = 0; start = 0;
        chk("ss_busy_after", busy, 0);
        chk("ss_done", done, 1);
        chk("ss_io_o_held", io_o, 8'h11);
        tick();
        chk("ss_done_clr", done, 0);
        chk("ss_busy_idle", busy, 0);
        chk("ss_io_o_held2", io_o, 8'h11);

        start = 1; tick(); start = 0;
        clear = 1; tick(); clear = 0;
        stop = 1; tick(); stop = 0;
        chk("busy_clear_ignored", entry_cnt, DEPTH);
        clear = 1; wr_valid = 1; wr_data = 8'h77; tick(); clear = 0; wr_valid = 0;
        chk("clear_beats_write", entry_cnt, 0);

        pd = '{8'h12, 8'h34};
        ph = '{4, 4};
        load();
        start = 1; tick(); start = 0;
        tick();
        chk("mid_busy", busy, 1);
        resetn = 0;
        m_q = '0; m_data = '0; m_mask = '0; m_valid = 0; m_count = '0;
        #1;
        chk("arst_io_o", io_o, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_entry_cnt", entry_cnt, 0);
        chk("arst_chg_count", chg_count, 0);
        chk("arst_chg_valid", chg_valid, 0);
        @(posedge clk); #1;
        chk("arst_done_hold", done, 0);
        resetn = 1;
        tick();
        chk("arst_done_after", done, 0);
        chk("arst_busy_after", busy, 0);

        rand_io = 1;
        repeat (15) begin
            int n;
            n = $urandom_range(1, 5);
            pd.delete();
            ph.delete();
            for (int k = 0; k < n; k++) begin
                pd.push_back(WIDTH'($urandom));
                ph.push_back($urandom_range(0, 3));
            end
            load();
            run_pattern($urandom_range(1, 3));
        end
        rand_io = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/io_pattern_vip.md
IO_PATTERN_VIP -- requirements
Module: io_pattern_vip

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8, giving the IO bus width in bits (1..32).
- REQ-002: The block SHALL have parameter DEPTH, default 16, giving the pattern buffer depth in entries (a power of 2, 2..256).
- REQ-003: The block SHALL have parameter HOLD_W, default 16, giving the hold-count field width in bits.
- REQ-004: The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and resetn.
- REQ-005: clk  in  1  rising-edge clock for all state.
- REQ-006: resetn  in  1  asynchronous active-low reset.
- REQ-007: wr_valid  in  1  pattern-entry write request.
- REQ-008: wr_ready  out  1  entry accepted when wr_valid and wr_ready are both high.
- REQ-009: wr_data  in  WIDTH  value to drive for the entry.
- REQ-010: wr_hold  in  HOLD_W  number of cycles to hold the entry.
- REQ-011: clear  in  1  empties the pattern buffer.
- REQ-012: start  in  1  begins playback.
- REQ-013: stop  in  1  aborts playback.
- REQ-014: loop_en  in  1  repeat the pattern continuously.
- REQ-015: busy  out  1  high while in DRIVE.
- REQ-016: done  out  1  one-cycle pulse when playback ends.
- REQ-017: entry_cnt  out  $clog2(DEPTH)+1  number of stored entries.
- REQ-018: io_o  out  WIDTH  registered driven value.
- REQ-019: io_i  in  WIDTH  monitored input bus.
- REQ-020: chg_valid  out  1  one-cycle pulse when io_i changes.
- REQ-021: chg_data  out  WIDTH  new io_i value.
- REQ-022: chg_mask  out  WIDTH  bits that toggled.
- REQ-023: chg_count  out  16  saturating count of changes.

Function
- REQ-024: The block SHALL accept a write when wr_valid && wr_ready, store it at index entry_cnt, and increment entry_cnt in the next cycle.
- REQ-025: wr_ready SHALL equal !busy && entry_cnt<DEPTH; writes offered while full or busy SHALL be ignored and leave the stored entries unchanged.
- REQ-026: The state machine SHALL have the states IDLE and DRIVE.
- REQ-027: In IDLE, start with entry_cnt>0 SHALL move the block to DRIVE, set idx=0, load io_o=data[0], and set the hold counter to max(hold[0],1), all at the same edge.
- REQ-028: In IDLE, start with entry_cnt==0 SHALL have no effect, and done SHALL NOT pulse.
- REQ-029: In DRIVE, entry k SHALL be visible on io_o for exactly max(hold[k],1) cycles, and a hold of 0 SHALL count as 1.
- REQ-030: When the hold count of the last entry (idx==entry_cnt-1) expires with loop_en=1, the block SHALL wrap to idx=0 with no gap cycle.
- REQ-031: When that hold count expires with loop_en=0, the block SHALL go to IDLE, pulse done for 1 cycle, and hold io_o at the last value.
- REQ-032: loop_en SHALL be sampled only at the wrap point, so clearing it mid-pattern finishes the current pass.
- REQ-033: stop in DRIVE SHALL move the block to IDLE at the next edge, hold io_o at its current value, and pulse done; stop has priority over start and over a hold expiry in the same cycle.
- REQ-034: start while busy SHALL be ignored.
- REQ-035: clear in IDLE SHALL set entry_cnt=0 at the next edge, and clear SHALL win over a simultaneous write.
- REQ-036: clear while busy SHALL be ignored.
- REQ-037: The monitor SHALL register io_i into io_q every cycle, with io_q resetting to 0.
- REQ-038: When io_i != io_q, the block SHALL pulse chg_valid at the next edge with chg_data=io_i and chg_mask=io_i^io_q, both held until the next change.
- REQ-039: chg_count SHALL increment by 1 per chg_valid and saturate at 16'hFFFF.
- REQ-040: The monitor SHALL run independently of the IDLE/DRIVE state machine.

Reset
- REQ-041: On resetn low, asynchronously, the block SHALL set state=IDLE, busy=0, done=0, io_o=0, entry_cnt=0, idx=0, hold counter=0, io_q=0, chg_valid=0, chg_data=0, chg_mask=0 and chg_count=0.
- REQ-042: Reset asserted mid-DRIVE SHALL abort playback with no done pulse, and buffer contents need not be cleared.
- REQ-043: After reset release, the first nonzero io_i SHALL report as a change against 0.

Verification
- REQ-044: The bench SHALL write (0xA5,h=3), (0x3C,h=0), (0xFF,h=2) and then start -> io_o=A5 for 3 cycles, 3C for 1, FF for 2; then done pulses, busy=0 and io_o stays FF.
- REQ-045: The bench SHALL run the same pattern with loop_en=1 for two passes -> no gap between FF and A5; then deassert loop_en -> one more full pass and done.
- REQ-046: The bench SHALL write DEPTH+2 entries -> wr_ready=0 after DEPTH accepts, and entry_cnt=DEPTH.
- REQ-047: The bench SHALL assert stop and start together during DRIVE -> IDLE next edge, done pulses, and io_o is held.
- REQ-048: The bench SHALL drive io_i 0x00->0x81->0x81->0x01 -> two chg_valid pulses with masks 0x81 and 0x80, and chg_count=2.
- REQ-049: The bench SHALL assert resetn low mid-DRIVE -> all outputs 0 immediately, and no done pulse.
